pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the RV32I core.
- Watches decoder read addresses, EX-stage load/jump status and the data-memory handshake.
- Drives per-stage stall and flush strobes for the fetch/IF-ID/ID-EX/EX-MEM pipeline registers, plus the PC redirect.
- Owns the memory-wait FSM with timeout and the ebreak halt state.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_hazard_unit.sv | 14 +
 rtl/pipe_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared widths and FSM state encodings for the pipeline sequencing controller.
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define REG_ADDR_WIDTH 5
`define INST_ADDR_WIDTH 32
`define ZERO_REG 5'd0
`endif

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_e;

  localparam int TMO_W = 16;

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// Load-use hazard detect: a load in EX whose destination feeds the instruction in ID.
module hazard_unit (
  input  logic                        ex_mem_read_i,
  input  logic [`REG_ADDR_WIDTH-1:0]  ex_rd_waddr_i,
  input  logic [`REG_ADDR_WIDTH-1:0]  id_rs1_raddr_i,
  input  logic [`REG_ADDR_WIDTH-1:0]  id_rs2_raddr_i,
  output logic                        load_use_o
);

  // x0 never carries a real dependency, so a load targeting it needs no bubble.
  assign load_use_o = ex_mem_read_i && (ex_rd_waddr_i != `ZERO_REG) &&
                      ((ex_rd_waddr_i == id_rs1_raddr_i) || (ex_rd_waddr_i == id_rs2_raddr_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller with memory-wait timeout and ebreak halt.
// Optional performance counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [`REG_ADDR_WIDTH-1:0]   id_rs1_raddr_i,
  input  logic [`REG_ADDR_WIDTH-1:0]   id_rs2_raddr_i,
  input  logic                         id_ebreak_i,
  input  logic [`REG_ADDR_WIDTH-1:0]   ex_rd_waddr_i,
  input  logic                         ex_mem_read_i,
  input  logic                         ex_jump_req_i,
  input  logic [`INST_ADDR_WIDTH-1:0]  ex_jump_addr_i,
  input  logic                         mem_req_i,
  input  logic                         mem_ack_i,
  input  logic                         resume_i,
  output logic                         stall_pc_o,
  output logic                         stall_if_id_o,
  output logic                         stall_id_ex_o,
  output logic                         stall_ex_mem_o,
  output logic                         flush_if_id_o,
  output logic                         flush_id_ex_o,
  output logic                         jump_o,
  output logic [`INST_ADDR_WIDTH-1:0]  jump_addr_o,
  output logic                         mem_err_o,
  output logic                         halted_o,
  output logic [CNT_W-1:0]             stall_cnt_o,
  output logic [CNT_W-1:0]             flush_cnt_o
);

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mem_err_q, mem_err_d;
  logic              load_use;

  hazard_unit u_hazard (
    .ex_mem_read_i  (ex_mem_read_i),
    .ex_rd_waddr_i  (ex_rd_waddr_i),
    .id_rs1_raddr_i (id_rs1_raddr_i),
    .id_rs2_raddr_i (id_rs2_raddr_i),
    .load_use_o     (load_use)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_RUN;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    tmo_d          = tmo_q;
    mem_err_d      = 1'b0;
    stall_pc_o     = 1'b0;
    stall_if_id_o  = 1'b0;
    stall_id_ex_o  = 1'b0;
    stall_ex_mem_o = 1'b0;
    flush_if_id_o  = 1'b0;
    flush_id_ex_o  = 1'b0;
    jump_o         = 1'b0;
    jump_addr_o    = '0;
    halted_o       = 1'b0;
    case (state_q)
      S_RUN: begin
        // Oldest stage wins: a stalled memory access freezes even a resolved jump.
        if (mem_req_i && !mem_ack_i) begin
          stall_pc_o     = 1'b1;
          stall_if_id_o  = 1'b1;
          stall_id_ex_o  = 1'b1;
          stall_ex_mem_o = 1'b1;
          state_d        = S_MEM_WAIT;
          tmo_d          = TMO_W'(1);
        end else if (ex_jump_req_i) begin
          jump_o        = 1'b1;
          jump_addr_o   = ex_jump_addr_i;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end else if (load_use) begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end else if (id_ebreak_i) begin
          flush_if_id_o = 1'b1;
          stall_pc_o    = 1'b1;
          state_d       = S_HALT;
        end
      end
      S_MEM_WAIT: begin
        stall_pc_o     = !mem_ack_i;
        stall_if_id_o  = !mem_ack_i;
        stall_id_ex_o  = !mem_ack_i;
        stall_ex_mem_o = !mem_ack_i;
        // An ack arriving on the final allowed cycle still wins over the timeout.
        if (mem_ack_i) begin
          state_d = S_RUN;
          tmo_d   = '0;
        end else if (tmo_q == TMO_MAX) begin
          mem_err_d = 1'b1;
          state_d   = S_RUN;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_HALT: begin
        halted_o      = 1'b1;
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        if (resume_i) state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
        tmo_d   = '0;
      end
    endcase
    if (!rst) begin
      stall_pc_o     = 1'b0;
      stall_if_id_o  = 1'b0;
      stall_id_ex_o  = 1'b0;
      stall_ex_mem_o = 1'b0;
      flush_if_id_o  = 1'b0;
      flush_id_ex_o  = 1'b0;
      jump_o         = 1'b0;
      jump_addr_o    = '0;
      halted_o       = 1'b0;
    end
  end

  assign mem_err_o = mem_err_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_pc_o)    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_id_ex_o) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with a queue-based scoreboard (MEM_TIMEOUT=4).
module tb_pipe_ctrl;

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ebreak;
    logic [4:0]  rd;
    logic        mem_read;
    logic        jump_req;
    logic [31:0] jaddr;
    logic        mem_req;
    logic        mem_ack;
    logic        resume;
  } in_t;

  typedef struct packed {
    logic        spc;
    logic        sifid;
    logic        sidex;
    logic        sexmem;
    logic        fifid;
    logic        fidex;
    logic        jump;
    logic [31:0] jaddr;
    logic        err;
    logic        halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs1_raddr_i = '0, id_rs2_raddr_i = '0, ex_rd_waddr_i = '0;
  logic        id_ebreak_i = 1'b0, ex_mem_read_i = 1'b0, ex_jump_req_i = 1'b0;
  logic [31:0] ex_jump_addr_i = '0;
  logic        mem_req_i = 1'b0, mem_ack_i = 1'b0, resume_i = 1'b0;
  logic        stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o;
  logic        flush_if_id_o, flush_id_ex_o, jump_o, mem_err_o, halted_o;
  logic [31:0] jump_addr_o, stall_cnt_o, flush_cnt_o;

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_raddr_i(id_rs1_raddr_i), .id_rs2_raddr_i(id_rs2_raddr_i),
    .id_ebreak_i(id_ebreak_i), .ex_rd_waddr_i(ex_rd_waddr_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_jump_req_i(ex_jump_req_i),
    .ex_jump_addr_i(ex_jump_addr_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .resume_i(resume_i), .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o),
    .stall_id_ex_o(stall_id_ex_o), .stall_ex_mem_o(stall_ex_mem_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .jump_o(jump_o), .jump_addr_o(jump_addr_o), .mem_err_o(mem_err_o),
    .halted_o(halted_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  exp_t   exp_q[$];
  string  name_q[$];
  logic   rst_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  logic [31:0] exp_scnt = '0, exp_fcnt = '0;

  function automatic in_t idle();
    in_t t;
    t = '0;
    t.rst = 1'b1;
    return t;
  endfunction

  // Strobe pattern order: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, jump}
  function automatic exp_t ex(input logic [6:0] s, input logic [31:0] ja, input logic err, input logic h);
    exp_t e;
    e = {s, ja, err, h};
    return e;
  endfunction

  task automatic step(input in_t i, input exp_t e, input string nm);
    @(posedge clk);
    #1;
    rst            = i.rst;
    id_rs1_raddr_i = i.rs1;
    id_rs2_raddr_i = i.rs2;
    id_ebreak_i    = i.ebreak;
    ex_rd_waddr_i  = i.rd;
    ex_mem_read_i  = i.mem_read;
    ex_jump_req_i  = i.jump_req;
    ex_jump_addr_i = i.jaddr;
    mem_req_i      = i.mem_req;
    mem_ack_i      = i.mem_ack;
    resume_i       = i.resume;
    exp_q.push_back(e);
    name_q.push_back(nm);
    rst_q.push_back(i.rst);
  endtask

  always @(negedge clk) begin
    exp_t  e, got;
    string nm;
    logic  r;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      r  = rst_q.pop_front();
      got = {stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, flush_if_id_o,
             flush_id_ex_o, jump_o, jump_addr_o, mem_err_o, halted_o};
      n_vec++;
      if (got !== e || stall_cnt_o !== exp_scnt || flush_cnt_o !== exp_fcnt) begin
        n_err++;
        $display("FAIL %s: got %h scnt=%0d fcnt=%0d, expected %h scnt=%0d fcnt=%0d",
                 nm, got, stall_cnt_o, flush_cnt_o, e, exp_scnt, exp_fcnt);
      end
`ifdef PIPE_CTRL_PERF_CNT_EN
      if (!r) begin
        exp_scnt = '0;
        exp_fcnt = '0;
      end else begin
        exp_scnt = exp_scnt + {31'd0, e.spc};
        exp_fcnt = exp_fcnt + {31'd0, e.fidex};
      end
`endif
    end
  end

  initial begin
    in_t i;
    // reset forces every combinational output low even with active inputs
    i = idle(); i.rst = 1'b0; i.jump_req = 1'b1; i.jaddr = 32'h100; i.ebreak = 1'b1;
    step(i, ex(7'b0000000, 32'h0, 1'b0, 1'b0), "reset_force");
    i = idle(); i.rst = 1'b0;
    step(i, ex(7'b0000000, 32'h0, 1'b0, 1'b0), "reset_idle");
    step(idle(), ex(7'b0000000, 32'h0, 1'b0, 1'b0), "idle");
    // load-use on rs2, then self-clear
    i = idle(); i.mem_read = 1'b1; i.rd = 5'd5; i.rs2 = 5'd5;
    step(i, ex(7'b1100010, 32'h0, 1'b0, 1'b0), "lu_rs2");
    step(idle(), ex(7'b0000000, 32'h0, 1'b0, 1'b0), "lu_clear");
    i = idle(); i.mem_read = 1'b1; i.rd = 5'd0; i.rs1 = 5'd0; i.rs2 = 5'd0;
    step(i, ex(7'b0000000, 32'h0, 1'b0, 1'b0), "lu_x0");
    i = idle(); i.mem_read = 1'b1; i.rd = 5'd7; i.rs1 = 5'd7;
    step(i, ex(7'b1100010, 32'h0, 1'b0, 1'b0), "lu_rs1");
    i = idle(); i.rd = 5'd7; i.rs1 = 5'd7;
    step(i, ex(7'b0000000, 32'h0, 1'b0, 1'b0), "no_load");
    // jump outranks a load-use and an ebreak in the same cycle
    i = idle(); i.jump_req = 1'b1; i.jaddr = 32'h0000_0100; i.mem_read = 1'b1;
    i.rd = 5'd5; i.rs2 = 5'd5; i.ebreak = 1'b1;
    step(i, ex(7'b0000111, 32'h100, 1'b0, 1'b0), "jump_lu");
    step(idle(), ex(7'b0000000, 32'h0, 1'b0, 1'b0), "post_jump");
    // request acked in the same cycle: no stall
    i = idle(); i.mem_req = 1'b1; i.mem_ack = 1'b1;
    step(i, ex(7'b0000000, 32'h0, 1'b0, 1'b0), "mem_fast");
    // memory wait with ack arriving on the timeout cycle
    i = idle(); i.mem_req = 1'b1; i.jump_req = 1'b1; i.jaddr = 32'h200;
    step(i, ex(7'b1111000, 32'h0, 1'b0, 1'b0), "mem_stall_jump_held");
    i = idle(); i.mem_req = 1'b1;
    for (int k = 0; k < 3; k++) step(i, ex(7'b1111000, 32'h0, 1'b0, 1'b0), "mem_wait");
    i.mem_ack = 1'b1;
    step(i, ex(7'b0000000, 32'h0, 1'b0, 1'b0), "mem_ack_at_limit");
    step(idle(), ex(7'b0000000, 32'h0, 1'b0, 1'b0), "mem_no_err");
    // timeout: four wait cycles then a one-cycle error pulse
    i = idle(); i.mem_req = 1'b1;
    step(i, ex(7'b1111000, 32'h0, 1'b0, 1'b0), "tmo_enter");
    for (int k = 0; k < 4; k++) step(i, ex(7'b1111000, 32'h0, 1'b0, 1'b0), "tmo_wait");
    step(idle(), ex(7'b0000000, 32'h0, 1'b1, 1'b0), "tmo_err");
    step(idle(), ex(7'b0000000, 32'h0, 1'b0, 1'b0), "tmo_err_one_cycle");
    // ebreak halt, jump ignored, resume
    i = idle(); i.ebreak = 1'b1;
    step(i, ex(7'b1000100, 32'h0, 1'b0, 1'b0), "ebreak");
    i = idle(); i.jump_req = 1'b1; i.jaddr = 32'h200;
    step(i, ex(7'b1100010, 32'h0, 1'b0, 1'b1), "halt_ignore_jump");
    step(idle(), ex(7'b1100010, 32'h0, 1'b0, 1'b1), "halt_hold");
    i = idle(); i.resume = 1'b1;
    step(i, ex(7'b1100010, 32'h0, 1'b0, 1'b1), "halt_resume");
    step(idle(), ex(7'b0000000, 32'h0, 1'b0, 1'b0), "resumed");
    // reset while halted
    i = idle(); i.ebreak = 1'b1;
    step(i, ex(7'b1000100, 32'h0, 1'b0, 1'b0), "ebreak2");
    step(idle(), ex(7'b1100010, 32'h0, 1'b0, 1'b1), "halt2");
    i = idle(); i.rst = 1'b0;
    step(i, ex(7'b0000000, 32'h0, 1'b0, 1'b0), "rst_in_halt");
    step(idle(), ex(7'b0000000, 32'h0, 1'b0, 1'b0), "after_halt_rst");
    // reset while waiting on memory: no error pulse afterwards
    i = idle(); i.mem_req = 1'b1;
    step(i, ex(7'b1111000, 32'h0, 1'b0, 1'b0), "wait_enter");
    i.rst = 1'b0;
    step(i, ex(7'b0000000, 32'h0, 1'b0, 1'b0), "rst_in_wait");
    step(idle(), ex(7'b0000000, 32'h0, 1'b0, 1'b0), "after_wait_rst");
    step(idle(), ex(7'b0000000, 32'h0, 1'b0, 1'b0), "final_idle");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
